onehot_scan_decoder: RTL

//  Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with an auto-scan mode.

---
 rtl/onehot_scan_decoder.sv | 104 ++++++++++
 1 files changed

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with an auto-scan mode that
// steps the hot bit through every output, holding each position DWELL cycles.
module onehot_scan_decoder #(
   parameter int SEL_W = 2,
   parameter int DWELL = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    mode,
   input  logic                    load,
   input  logic [SEL_W-1:0]        sel,
   output logic [(1<<SEL_W)-1:0]   out,
   output logic [SEL_W-1:0]        idx,
   output logic                    valid,
   output logic                    wrap
);

   localparam int NOUT   = 1 << SEL_W;
   localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0]  IDX_LAST  = {SEL_W{1'b1}};

   typedef enum logic [1:0] {
      S_BLANK  = 2'd0,
      S_DIRECT = 2'd1,
      S_SCAN   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_idx;
   logic [SEL_W-1:0]   w_idx_nxt;
   logic [DCNT_W-1:0]  r_dcnt;
   logic [DCNT_W-1:0]  w_dcnt_nxt;
   logic [DCNT_W-1:0]  w_dcnt_cur;
   logic [NOUT-1:0]    r_out;
   logic [NOUT-1:0]    w_out_nxt;
   logic               r_valid;
   logic               w_valid_nxt;
   logic               r_wrap;
   logic               w_wrap_nxt;

   // A DIRECT cycle always leaves the dwell count at zero, so scanning restarts cleanly.
   assign w_dcnt_cur = (r_state == S_DIRECT) ? '0 : r_dcnt;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_dcnt_nxt  = r_dcnt;
      w_valid_nxt = 1'b0;
      w_wrap_nxt  = 1'b0;

      if (!en) begin
         w_state_nxt = S_BLANK;
      end else if (!mode) begin
         w_state_nxt = S_DIRECT;
         w_idx_nxt   = sel;
         w_dcnt_nxt  = '0;
         w_valid_nxt = 1'b1;
      end else begin
         w_state_nxt = S_SCAN;
         w_valid_nxt = 1'b1;
         if (load) begin
            w_idx_nxt  = sel;
            w_dcnt_nxt = '0;
         end else if (w_dcnt_cur == DCNT_LAST) begin
            w_idx_nxt  = r_idx + SEL_W'(1);
            w_dcnt_nxt = '0;
            w_wrap_nxt = (r_idx == IDX_LAST);
         end else begin
            w_dcnt_nxt = w_dcnt_cur + DCNT_W'(1);
         end
      end

      w_out_nxt = w_valid_nxt ? (NOUT'(1) << w_idx_nxt) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_BLANK;
         r_idx   <= '0;
         r_dcnt  <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_out   <= w_out_nxt;
         r_valid <= w_valid_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign out   = r_out;
   assign idx   = r_idx;
   assign valid = r_valid;
   assign wrap  = r_wrap;

endmodule
